// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte/word helpers used by the key expansion and round logic.
// State byte n sits at bits [127-8n -: 8]; byte n = row + 4*col (column-major).
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned NR      = 10;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // LSB position of state byte (row, col): 8 * (15 - (row + 4*col)).
  function automatic logic [6:0] byte_lsb(input logic [1:0] row, input logic [1:0] col);
    return {~col, ~row, 3'b000};
  endfunction

  // LSB position of state column col: 32 * (3 - col).
  function automatic logic [6:0] col_lsb(input logic [1:0] col);
    return {~col, 5'b00000};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // One AES-128 key-schedule step: previous round key -> next round key.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rcon, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes128_encrypt_core_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes128_encrypt_core_round
  import aes_pkg::*;
#(
  parameter bit LAST = 1'b0
) (
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  output logic [127:0] o_state_c
);

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;

  always_comb begin
    w_sb = '0;
    w_sr = '0;
    w_mc = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_sb[byte_lsb(2'(r), 2'(c)) +: 8] = sbox(i_state[byte_lsb(2'(r), 2'(c)) +: 8]);
      end
    end
    // Row r rotates left by r columns; 2-bit column add wraps mod 4.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_sr[byte_lsb(2'(r), 2'(c)) +: 8] = w_sb[byte_lsb(2'(r), 2'(c) + 2'(r)) +: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mc[col_lsb(2'(c)) +: 32] = mix_column(w_sr[col_lsb(2'(c)) +: 32]);
    end
  end

  assign o_state_c = (LAST ? w_sr : w_mc) ^ i_round_key;

endmodule

// File: rtl/aes128_encrypt_core.sv
// Fully unrolled AES-128 encryptor with independently strobed key, round and output register stages.
module aes128_encrypt_core
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid_key_gen,
  input  logic               valid_round,
  input  logic               valid_out,
  input  logic [BLOCK_W-1:0] IN_DATA,
  input  logic [BLOCK_W-1:0] IN_KEY,
  output logic [BLOCK_W-1:0] OUT_DATA,
  output logic [BLOCK_W-1:0] round_key_0,
  output logic [BLOCK_W-1:0] round_key_1,
  output logic [BLOCK_W-1:0] round_key_2,
  output logic [BLOCK_W-1:0] round_key_3,
  output logic [BLOCK_W-1:0] round_key_4,
  output logic [BLOCK_W-1:0] round_key_5,
  output logic [BLOCK_W-1:0] round_key_6,
  output logic [BLOCK_W-1:0] round_key_7,
  output logic [BLOCK_W-1:0] round_key_8,
  output logic [BLOCK_W-1:0] round_key_9,
  output logic [BLOCK_W-1:0] round_key_10,
  output logic [BLOCK_W-1:0] round_data_0,
  output logic [BLOCK_W-1:0] round_data_1,
  output logic [BLOCK_W-1:0] round_data_2,
  output logic [BLOCK_W-1:0] round_data_3,
  output logic [BLOCK_W-1:0] round_data_4,
  output logic [BLOCK_W-1:0] round_data_5,
  output logic [BLOCK_W-1:0] round_data_6,
  output logic [BLOCK_W-1:0] round_data_7,
  output logic [BLOCK_W-1:0] round_data_8,
  output logic [BLOCK_W-1:0] round_data_9,
  output logic [BLOCK_W-1:0] round_data_10
);

  logic [BLOCK_W-1:0] w_key  [0:NR];
  logic [BLOCK_W-1:0] w_data [0:NR];
  logic [BLOCK_W-1:0] r_key  [0:NR];
  logic [BLOCK_W-1:0] r_data [0:NR];
  logic [BLOCK_W-1:0] r_out;

  // Key schedule is built directly from IN_KEY so it lands in one edge.
  assign w_key[0] = IN_KEY;
  for (genvar gi = 1; gi <= NR; gi++) begin : g_key
    assign w_key[gi] = key_step(w_key[gi-1], RCON[gi-1]);
  end

  // Round chain uses the registered keys, not the keys being loaded this edge.
  assign w_data[0] = IN_DATA ^ r_key[0];
  for (genvar gi = 1; gi <= NR; gi++) begin : g_round
    aes128_encrypt_core_round #(
      .LAST (gi == NR)
    ) u_round (
      .i_state     (w_data[gi-1]),
      .i_round_key (r_key[gi]),
      .o_state_c   (w_data[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_key  <= '{default: '0};
      r_data <= '{default: '0};
      r_out  <= '0;
    end else begin
      if (valid_key_gen) r_key  <= w_key;
      if (valid_round)   r_data <= w_data;
      if (valid_out)     r_out  <= r_data[NR];
    end
  end

  assign OUT_DATA      = r_out;
  assign round_key_0   = r_key[0];
  assign round_key_1   = r_key[1];
  assign round_key_2   = r_key[2];
  assign round_key_3   = r_key[3];
  assign round_key_4   = r_key[4];
  assign round_key_5   = r_key[5];
  assign round_key_6   = r_key[6];
  assign round_key_7   = r_key[7];
  assign round_key_8   = r_key[8];
  assign round_key_9   = r_key[9];
  assign round_key_10  = r_key[10];
  assign round_data_0  = r_data[0];
  assign round_data_1  = r_data[1];
  assign round_data_2  = r_data[2];
  assign round_data_3  = r_data[3];
  assign round_data_4  = r_data[4];
  assign round_data_5  = r_data[5];
  assign round_data_6  = r_data[6];
  assign round_data_7  = r_data[7];
  assign round_data_8  = r_data[8];
  assign round_data_9  = r_data[9];
  assign round_data_10 = r_data[10];

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core using FIPS-197 known-answer vectors.
module tb_aes128_encrypt_core;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         resetn;
  logic         valid_key_gen;
  logic         valid_round;
  logic         valid_out;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic [127:0] out_data;
  logic [127:0] rk [0:10];
  logic [127:0] rd [0:10];

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_q [$];
  string        tag_q [$];

  always #5 clk = ~clk;

  aes128_encrypt_core dut (
    .clk           (clk),
    .resetn        (resetn),
    .valid_key_gen (valid_key_gen),
    .valid_round   (valid_round),
    .valid_out     (valid_out),
    .IN_DATA       (in_data),
    .IN_KEY        (in_key),
    .OUT_DATA      (out_data),
    .round_key_0   (rk[0]),
    .round_key_1   (rk[1]),
    .round_key_2   (rk[2]),
    .round_key_3   (rk[3]),
    .round_key_4   (rk[4]),
    .round_key_5   (rk[5]),
    .round_key_6   (rk[6]),
    .round_key_7   (rk[7]),
    .round_key_8   (rk[8]),
    .round_key_9   (rk[9]),
    .round_key_10  (rk[10]),
    .round_data_0  (rd[0]),
    .round_data_1  (rd[1]),
    .round_data_2  (rd[2]),
    .round_data_3  (rd[3]),
    .round_data_4  (rd[4]),
    .round_data_5  (rd[5]),
    .round_data_6  (rd[6]),
    .round_data_7  (rd[7]),
    .round_data_8  (rd[8]),
    .round_data_9  (rd[9]),
    .round_data_10 (rd[10])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_out(input string tag, input logic [127:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_out();
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue expected an entry");
    end else begin
      check(tag_q.pop_front(), out_data, exp_q.pop_front());
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i <= 10; i++) begin
      check($sformatf("%s_rk%0d", tag, i), rk[i], 128'h0);
      check($sformatf("%s_rd%0d", tag, i), rd[i], 128'h0);
    end
    check($sformatf("%s_out", tag), out_data, 128'h0);
  endtask

  task automatic strobes(input logic k, input logic r, input logic o);
    valid_key_gen = k;
    valid_round   = r;
    valid_out     = o;
  endtask

  initial begin
    // Reset with every strobe high: reset must win.
    resetn  = 1'b1;
    in_key  = {$urandom, $urandom, $urandom, $urandom};
    in_data = {$urandom, $urandom, $urandom, $urandom};
    strobes(1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check_all_zero("reset");

    // Key expansion only.
    resetn = 1'b0;
    strobes(1'b1, 1'b0, 1'b0);
    in_key = KEY_A;
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    check("keyA_rk0", rk[0], KEY_A);
    check("keyA_rk1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("keyA_rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("keyA_rd0_untouched", rd[0], 128'h0);

    // Round stage, then output stage.
    in_data = PT_A;
    strobes(1'b0, 1'b1, 1'b0);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    check("ptA_rd0", rd[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("ptA_rd1", rd[1], 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("ptA_rd10", rd[10], CT_A);
    check("ptA_out_not_yet", out_data, 128'h0);
    push_out("ptA_out", CT_A);
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    pop_out();

    // Fresh reset, then all three strobes held together.
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    in_key  = KEY_B;
    in_data = PT_B;
    strobes(1'b1, 1'b1, 1'b1);
    push_out("pipe_edge1_out", 128'h0);
    tick();
    pop_out();
    check("pipe_edge1_rk0", rk[0], KEY_B);
    check("pipe_edge1_rd0_zero_key", rd[0], PT_B);
    tick();
    check("pipe_edge2_rk1", rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("pipe_edge2_rd0", rd[0], 128'h00102030405060708090a0b0c0d0e0f0);
    check("pipe_edge2_rd1", rd[1], 128'h89d810e8855ace682d1843d8cb128fe4);
    check("pipe_edge2_rd10", rd[10], CT_B);
    push_out("pipe_edge3_out", CT_B);
    tick();
    pop_out();

    // Strobes low: everything must hold while inputs churn.
    strobes(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_key  = {$urandom, $urandom, $urandom, $urandom};
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    check("hold_rk0", rk[0], KEY_B);
    check("hold_rk1", rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("hold_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("hold_rd0", rd[0], 128'h00102030405060708090a0b0c0d0e0f0);
    check("hold_rd10", rd[10], CT_B);
    check("hold_out", out_data, CT_B);

    // Reset between key and round stages, then full re-run.
    in_key = KEY_A;
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    check("mid_rk0_loaded", rk[0], KEY_A);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    check_all_zero("midrst");
    strobes(1'b1, 1'b0, 1'b0);
    tick();
    in_data = PT_A;
    strobes(1'b0, 1'b1, 1'b0);
    tick();
    check("rerun_rd10", rd[10], CT_A);
    push_out("rerun_out", CT_A);
    strobes(1'b0, 1'b0, 1'b1);
    tick();
    strobes(1'b0, 1'b0, 1'b0);
    pop_out();

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_core.md
Name: aes128_encrypt_core

Overview:
- Single-block AES-128 encryptor (FIPS-197), fully unrolled.
- Three independently enabled register stages:
  - key expansion into 11 round keys;
  - 11 intermediate round states computed in one cycle;
  - final ciphertext capture.
- Exposes every round key and round state for debug/verification.
- Sits as a leaf crypto engine under a controller that sequences the three valid strobes.

Parameters:
- none (key size fixed at 128, Nr = 10)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- resetn  in  1  reset, synchronous, active-high (port keeps this name; 1 = reset)
- valid_key_gen  in  1  load/expand IN_KEY into round_key_0..10 on this edge
- valid_round  in  1  compute and register round_data_0..10 from IN_DATA and the current round keys
- valid_out  in  1  copy round_data_10 into OUT_DATA
- IN_DATA  in  128  plaintext block
- IN_KEY  in  128  cipher key
- OUT_DATA  out  128  registered ciphertext
- round_key_0..round_key_10  out  128 each  registered expanded round keys
- round_data_0..round_data_10  out  128 each  registered round states

Behaviour:
- Byte order (FIPS-197):
  - bits [127:120] = byte 0;
  - state is column-major: bytes 0-3 form column 0.
- Reset:
  - when resetn=1 at a clock edge, every output register clears to 128'h0;
  - reset has priority over all valid strobes.
- Key stage:
  - on an edge with valid_key_gen=1, round_key_0 <= IN_KEY;
  - round_key_1..10 <= standard AES-128 expansion of IN_KEY: RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36.
  - The expansion is combinational from IN_KEY; latency is 1 cycle.
  - Otherwise the round keys hold.
- Round stage:
  - on an edge with valid_round=1, round_data_0 <= IN_DATA ^ round_key_0;
  - round_data_i for i=1..9 <= MixColumns(ShiftRows(SubBytes(round_data_{i-1}))) ^ round_key_i;
  - round_data_10 <= ShiftRows(SubBytes(round_data_9)) ^ round_key_10.
  - The whole chain is combinational from IN_DATA and the currently registered round keys; latency is 1 cycle.
  - Otherwise the round states hold.
- Output stage:
  - on an edge with valid_out=1, OUT_DATA <= registered round_data_10 (value before this edge's update);
  - otherwise OUT_DATA holds.
- Simultaneous strobes:
  - each stage samples the other stages' pre-edge register values.
  - If all three strobes are held high continuously, the correct ciphertext is on OUT_DATA after the 3rd edge; the round keys are valid after the 1st edge and the round states after the 2nd.
- Inputs may change every cycle; there is no internal holding of IN_KEY or IN_DATA beyond the registers above.
- Mid-operation reset: clears all stages; keys must be regenerated before data is valid.
- Strobes deasserted: outputs are frozen indefinitely.

Decomposition:
- Shared package aes_pkg holds:
  - the 10-entry Rcon constant array;
  - the GF(2^8) xtime function;
  - the SubWord/RotWord helpers;
  - state byte-index helpers.
- One natural sub-module is aes_sbox: a combinational 8-bit S-box lookup, instantiated 16× per round and 4× per key-expansion step (or shared via package function).

Test Plan:
- Reset: assert resetn=1 for 2 edges with strobes high -> all round_key_*, round_data_*, OUT_DATA = 0.
- Key expansion: IN_KEY=2b7e151628aed2a6abf7158809cf4f3c, valid_key_gen for 1 edge:
  - round_key_0 = the key;
  - round_key_1 = a0fafe1788542cb123a339392a6c7605;
  - round_key_10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Rounds: with the above keys, IN_DATA=3243f6a8885a308d313198a2e0370734, valid_round for 1 edge:
  - round_data_0 = 193de3bea0f4e22b9ac68d2ae9f84808;
  - round_data_1 = a49c7ff2689f352b6b5bea43026a5049;
  - round_data_10 = 3925841d02dc09fbdc118597196a0b32.
  - Then valid_out for 1 edge -> OUT_DATA = 3925841d02dc09fbdc118597196a0b32.
- Pipelined strobes: IN_KEY=000102030405060708090a0b0c0d0e0f, IN_DATA=00112233445566778899aabbccddeeff, all three strobes high from the same edge:
  - after edge 1, OUT_DATA is still 0 and the round_data_* values are computed with reset-zero keys;
  - after edge 3, OUT_DATA = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Hold: after the previous test, drop all strobes and change IN_KEY/IN_DATA randomly for 10 cycles -> all outputs unchanged.
- Mid-operation reset: assert resetn for 1 edge between the key and round stages -> all outputs 0; a re-run with valid_key_gen followed by valid_round reproduces the expected ciphertext.
